// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state type and the single-cycle ALU function for alu_seq.
package alu_seq_pkg;

   // Widest datapath the single-cycle function supports; narrower users zero-extend.
   localparam int unsigned MaxWidth = 64;

   localparam logic [2:0] ALU_ADD  = 3'b000;
   localparam logic [2:0] ALU_SUB  = 3'b001;
   localparam logic [2:0] ALU_AND  = 3'b010;
   localparam logic [2:0] ALU_NOT  = 3'b011;
   localparam logic [2:0] ALU_OR   = 3'b100;
   localparam logic [2:0] ALU_XOR  = 3'b101;
   localparam logic [2:0] ALU_MUL  = 3'b110;
   localparam logic [2:0] ALU_PASS = 3'b111;

   typedef enum logic {S_IDLE, S_MUL} alu_state_e;

   typedef struct packed {
      logic [MaxWidth-1:0] res;
      logic                v;
   } alu_res_t;

   // Result is masked to `width` bits; V uses the sign bit at position width-1.
   function automatic alu_res_t alu_single(input logic [2:0]          op,
                                           input logic [MaxWidth-1:0] a,
                                           input logic [MaxWidth-1:0] b,
                                           input int unsigned         width);
      logic [MaxWidth-1:0] mask;
      logic [MaxWidth-1:0] msb;
      logic [MaxWidth-1:0] r;
      logic                sa;
      logic                sb;
      logic                sr;
      alu_res_t            o;
      mask = (width >= MaxWidth) ? '1 : ((MaxWidth'(1) << width) - MaxWidth'(1));
      msb  = MaxWidth'(1) << (width - 1);
      case (op)
         ALU_ADD:  r = a + b;
         ALU_SUB:  r = a - b;
         ALU_AND:  r = a & b;
         ALU_NOT:  r = ~b;
         ALU_OR:   r = a | b;
         ALU_XOR:  r = a ^ b;
         ALU_PASS: r = b;
         default:  r = '0;
      endcase
      r  = r & mask;
      sa = |(a & msb);
      sb = |(b & msb);
      sr = |(r & msb);
      o.res = r;
      if (op == ALU_ADD) begin
         o.v = (sa == sb) && (sr != sa);
      end else if (op == ALU_SUB) begin
         o.v = (sa != sb) && (sr != sa);
      end else begin
         o.v = 1'b0;
      end
      return o;
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the controller (master) and alu_seq (slave).
interface alu_seq_if #(
   parameter int unsigned WIDTH = 16
);
   logic             start;
   logic [2:0]       ALUop;
   logic [WIDTH-1:0] Ain;
   logic [WIDTH-1:0] Bin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] out;
   logic             Z;
   logic             N;
   logic             V;

   modport master (
      output start, ALUop, Ain, Bin,
      input  busy, done, out, Z, N, V
   );

   modport slave (
      input  start, ALUop, Ain, Bin,
      output busy, done, out, Z, N, V
   );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add unsigned multiplier: one partial product per cycle, WIDTH cycles.
module alu_mul_seq #(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] prod_lo_o,
   output logic             ovf_o
);
   localparam int unsigned         CntW    = $clog2(WIDTH + 1);
   localparam logic [CntW-1:0]     CntLast = CntW'(WIDTH);

   logic [2*WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0]   mplier_q, mplier_d;
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic               run_q, run_d;

   assign ready_o   = run_q && (cnt_q == CntLast);
   assign prod_lo_o = acc_q[WIDTH-1:0];
   assign ovf_o     = |acc_q[2*WIDTH-1:WIDTH];

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      run_d    = run_q;
      if (load_i) begin
         mcand_d  = {{WIDTH{1'b0}}, a_i};
         mplier_d = b_i;
         acc_d    = '0;
         cnt_d    = '0;
         run_d    = 1'b1;
      end else if (run_q) begin
         if (cnt_q != CntLast) begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[2*WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CntW'(1);
         end else begin
            // Product is consumed on this edge by the top.
            run_d = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         run_q    <= 1'b0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         run_q    <= run_d;
      end
   end

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU: registered result and N/V/Z flags, one-cycle ops plus iterative multiply.
module alu_seq
   import alu_seq_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic      clk,
   input  logic      rst_n,
   alu_seq_if.slave  bus
);
   alu_state_e       state_q;
   logic [WIDTH-1:0] out_q;
   logic             z_q;
   logic             n_q;
   logic             v_q;
   logic             done_q;
   // Single-cycle ops are latched at acceptance and committed on the following edge.
   logic             pend_q;
   logic [2:0]       sop_q;
   logic [WIDTH-1:0] sa_q;
   logic [WIDTH-1:0] sb_q;

   logic             mul_load;
   logic             mul_ready;
   logic             mul_ovf;
   logic [WIDTH-1:0] mul_lo;
   logic [WIDTH-1:0] single_res;
   alu_res_t         single;
   logic             unused_res;

   assign mul_load   = (state_q == S_IDLE) && bus.start && (bus.ALUop == ALU_MUL);
   assign single     = alu_single(sop_q, MaxWidth'(sa_q), MaxWidth'(sb_q), WIDTH);
   assign single_res = single.res[WIDTH-1:0];
   assign unused_res = ^single.res;

   assign bus.busy = (state_q == S_MUL);
   assign bus.done = done_q;
   assign bus.out  = out_q;
   assign bus.Z    = z_q;
   assign bus.N    = n_q;
   assign bus.V    = v_q;

   alu_mul_seq #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk       (clk),
      .rst_n     (rst_n),
      .load_i    (mul_load),
      .a_i       (bus.Ain),
      .b_i       (bus.Bin),
      .ready_o   (mul_ready),
      .prod_lo_o (mul_lo),
      .ovf_o     (mul_ovf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         out_q   <= '0;
         z_q     <= 1'b0;
         n_q     <= 1'b0;
         v_q     <= 1'b0;
         done_q  <= 1'b0;
         pend_q  <= 1'b0;
         sop_q   <= ALU_ADD;
         sa_q    <= '0;
         sb_q    <= '0;
      end else begin
         done_q <= 1'b0;
         pend_q <= 1'b0;
         if (pend_q) begin
            out_q  <= single_res;
            z_q    <= (single_res == '0);
            n_q    <= single_res[WIDTH-1];
            v_q    <= single.v;
            done_q <= 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.ALUop == ALU_MUL) begin
                     state_q <= S_MUL;
                  end else begin
                     pend_q <= 1'b1;
                     sop_q  <= bus.ALUop;
                     sa_q   <= bus.Ain;
                     sb_q   <= bus.Bin;
                  end
               end
            end
            S_MUL: begin
               // start is ignored here; no single op can be pending in this state.
               if (mul_ready) begin
                  out_q   <= mul_lo;
                  z_q     <= (mul_lo == '0);
                  n_q     <= mul_lo[WIDTH-1];
                  v_q     <= mul_ovf;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule
